// File: rtl/ctx_mem_pkg.sv
// Shared types and helpers for the context-memory arbiter.
// The default-sized types document the standard 3-channel, 32-bit configuration.
package ctx_mem_pkg;

  localparam int CTX_NUM_CH = 3;
  localparam int CTX_ADDR_W = 32;
  localparam int CTX_DATA_W = 32;

  localparam int CORE_CH = 0;

  typedef logic [$clog2(CTX_NUM_CH)-1:0] ch_idx_t;

  typedef struct packed {
    logic                    we;
    logic [CTX_DATA_W/8-1:0] be;
    logic [CTX_ADDR_W-1:0]   addr;
    logic [CTX_DATA_W-1:0]   wdata;
  } mem_req_t;

  // Next round-robin start point: one past the winner, wrapping back to the first ctx channel.
  function automatic int rr_next(input int winner, input int num_ch);
    if (winner >= num_ch - 1) return 1;
    return winner + 1;
  endfunction

endpackage

// File: rtl/ctx_arb_id_fifo.sv
// Synchronous FIFO of channel indices, one entry per outstanding memory transaction.
// Push when full and pop when empty are ignored.
module ctx_arb_id_fifo #(
  parameter int IDX_W = 2,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [IDX_W-1:0] din,
  output logic [IDX_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ctx_mem_arbiter.sv
// N-channel arbiter for one OBI-style memory port with grant lock and response routing.
// Build option CTX_ARB_RR_EN: round-robin among ctx channels (default: fixed priority).
module ctx_mem_arbiter
  import ctx_mem_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH-1:0]            ch_req_i,
  input  logic [NUM_CH-1:0]            ch_we_i,
  input  logic [NUM_CH*DATA_W/8-1:0]   ch_be_i,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]     ch_wdata_i,
  output logic [NUM_CH-1:0]            ch_gnt_o,
  output logic [NUM_CH-1:0]            ch_rvalid_o,
  output logic [DATA_W-1:0]            ch_rdata_o,
  output logic                         mem_req_o,
  input  logic                         mem_gnt_i,
  output logic                         mem_we_o,
  output logic [DATA_W/8-1:0]          mem_be_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  input  logic                         mem_rvalid_i,
  input  logic [DATA_W-1:0]            mem_rdata_i,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
  output logic                         err_o
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int BE_W  = DATA_W / 8;

  typedef logic [IDX_W-1:0] idx_t;

  logic [BE_W-1:0]   be_a    [NUM_CH];
  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];

  idx_t sel;
  idx_t ctx_win;
  logic ctx_any;
  logic lock_vld;
  idx_t lock_idx;
  logic issue;
  logic fifo_full;
  logic fifo_empty;
  idx_t head;
  logic err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign be_a[g]    = ch_be_i[g*BE_W +: BE_W];
    assign addr_a[g]  = ch_addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = ch_wdata_i[g*DATA_W +: DATA_W];
  end

`ifdef CTX_ARB_RR_EN
  idx_t rr_ptr;

  // Scan ctx channels starting at the pointer; the first requester wins.
  always_comb begin
    int   c;
    idx_t ci;
    ctx_win = idx_t'(1);
    ctx_any = 1'b0;
    for (int k = 0; k < NUM_CH - 1; k++) begin
      c  = ((int'(rr_ptr) - 1 + k) % (NUM_CH - 1)) + 1;
      ci = idx_t'(c);
      if (!ctx_any && ch_req_i[ci]) begin
        ctx_any = 1'b1;
        ctx_win = ci;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= idx_t'(1);
    end else if (issue && sel != idx_t'(CORE_CH)) begin
      rr_ptr <= idx_t'(rr_next(int'(sel), NUM_CH));
    end
  end
`else
  // Descending scan so the lowest requesting ctx index overwrites the rest.
  always_comb begin
    idx_t ci;
    ctx_win = idx_t'(1);
    ctx_any = 1'b0;
    for (int k = NUM_CH - 1; k >= 1; k--) begin
      ci = idx_t'(k);
      if (ch_req_i[ci]) begin
        ctx_any = 1'b1;
        ctx_win = ci;
      end
    end
  end
`endif

  always_comb begin
    if (lock_vld)                  sel = lock_idx;
    else if (ch_req_i[CORE_CH])    sel = idx_t'(CORE_CH);
    else if (ctx_any)              sel = ctx_win;
    else                           sel = idx_t'(CORE_CH);
  end

  // No issue while the tracker is full, even if a response drains it this cycle.
  assign mem_req_o   = ch_req_i[sel] & ~fifo_full;
  assign issue       = mem_req_o & mem_gnt_i;
  assign mem_we_o    = mem_req_o & ch_we_i[sel];
  assign mem_be_o    = mem_req_o ? be_a[sel]    : '0;
  assign mem_addr_o  = mem_req_o ? addr_a[sel]  : '0;
  assign mem_wdata_o = mem_req_o ? wdata_a[sel] : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_route
    assign ch_gnt_o[g]    = issue & (sel == idx_t'(g));
    assign ch_rvalid_o[g] = mem_rvalid_i & ~fifo_empty & (head == idx_t'(g));
  end

  assign ch_rdata_o = mem_rdata_i;
  assign err_o      = err_q;

  // Lock holds the presented channel across stalls and wait states until it is granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else if (mem_req_o && !mem_gnt_i) begin
      lock_vld <= 1'b1;
      lock_idx <= sel;
    end else if (issue) begin
      lock_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                         err_q <= 1'b0;
    else if (mem_rvalid_i && fifo_empty) err_q <= 1'b1;
  end

  ctx_arb_id_fifo #(
    .IDX_W (IDX_W),
    .DEPTH (MAX_OUT)
  ) u_id_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (issue),
    .pop   (mem_rvalid_i),
    .din   (sel),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding_o)
  );

endmodule

// File: tb/tb_ctx_mem_arbiter.sv
// Directed scoreboard bench for ctx_mem_arbiter (default 3 channels, MAX_OUT=4).
// Expected response routing is queued as grants are predicted and checked on each rvalid.
module tb_ctx_mem_arbiter;

  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_we;
  logic [NUM_CH*4-1:0]      ch_be;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_gnt;
  logic [NUM_CH-1:0]        ch_rvalid;
  logic [DATA_W-1:0]        ch_rdata;
  logic                     mem_req;
  logic                     mem_gnt;
  logic                     mem_we;
  logic [3:0]               mem_be;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_rvalid;
  logic [DATA_W-1:0]        mem_rdata;
  logic [2:0]               outstanding;
  logic                     err;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  ctx_mem_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .ch_req_i(ch_req), .ch_we_i(ch_we), .ch_be_i(ch_be),
    .ch_addr_i(ch_addr), .ch_wdata_i(ch_wdata),
    .ch_gnt_o(ch_gnt), .ch_rvalid_o(ch_rvalid), .ch_rdata_o(ch_rdata),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .outstanding_o(outstanding), .err_o(err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic req, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    ch_req[i]           = req;
    ch_we[i]            = we;
    ch_be[i*4 +: 4]     = req ? 4'hF : 4'h0;
    ch_addr[i*32 +: 32] = addr;
    ch_wdata[i*32 +: 32] = wdata;
  endtask

  task automatic idle();
    @(negedge clk);
    ch_req     = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  // Drive one memory response and check it against the oldest predicted owner.
  task automatic rsp(input logic [31:0] data);
    int e;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    #1;
    n_tests++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_underflow: observed rvalid %0h expected no response", ch_rvalid);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rvalid_route", 64'(ch_rvalid), 64'd1 << e);
      check("rdata", 64'(ch_rdata), 64'(data));
    end
  endtask

  initial begin
    rst = 1'b1;
    ch_req = '0; ch_we = '0; ch_be = '0; ch_addr = '0; ch_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state
    @(negedge clk); #1;
    check("rst_gnt", 64'(ch_gnt), 0);
    check("rst_rvalid", 64'(ch_rvalid), 0);
    check("rst_mem_req", 64'(mem_req), 0);
    check("rst_mem_addr", 64'(mem_addr), 0);
    check("rst_outstanding", 64'(outstanding), 0);
    check("rst_err", 64'(err), 0);
    @(negedge clk); rst = 1'b0;

    // 1: core read, granted one cycle later, response routed to ch0
    @(negedge clk);
    set_ch(0, 1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    check("t1_mem_req", 64'(mem_req), 1);
    check("t1_mem_addr", 64'(mem_addr), 64'h100);
    check("t1_no_gnt", 64'(ch_gnt), 0);
    @(negedge clk); mem_gnt = 1'b1; #1;
    check("t1_gnt", 64'(ch_gnt), 64'b001);
    exp_q.push_back(0);
    idle(); #1;
    check("t1_outstanding", 64'(outstanding), 1);
    rsp(32'hDEADBEEF);
    idle(); #1;
    check("t1_drained", 64'(outstanding), 0);

    // 2: ch0 beats ch1, ch1 granted next cycle
    @(negedge clk);
    set_ch(0, 1'b1, 1'b1, 32'h110, 32'hA0A0A0A0);
    set_ch(1, 1'b1, 1'b0, 32'h210, 32'h0);
    mem_gnt = 1'b1; #1;
    check("t2_gnt_ch0", 64'(ch_gnt), 64'b001);
    check("t2_we", 64'(mem_we), 1);
    check("t2_wdata", 64'(mem_wdata), 64'hA0A0A0A0);
    exp_q.push_back(0);
    @(negedge clk); set_ch(0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    check("t2_gnt_ch1", 64'(ch_gnt), 64'b010);
    check("t2_addr_ch1", 64'(mem_addr), 64'h210);
    exp_q.push_back(1);
    idle(); #1;
    check("t2_outstanding", 64'(outstanding), 2);
    rsp(32'h11111111);
    rsp(32'h22222222);

    // 3: ch2 locked while memory stalls grant, ch0 arrives late
    @(negedge clk);
    mem_rvalid = 1'b0;
    set_ch(2, 1'b1, 1'b0, 32'h300, 32'h0);
    mem_gnt = 1'b0; #1;
    check("t3_addr_c0", 64'(mem_addr), 64'h300);
    @(negedge clk); set_ch(0, 1'b1, 1'b0, 32'h104, 32'h0); #1;
    check("t3_addr_c1", 64'(mem_addr), 64'h300);
    check("t3_no_gnt", 64'(ch_gnt), 0);
    @(negedge clk); #1;
    check("t3_addr_c2", 64'(mem_addr), 64'h300);
    @(negedge clk); mem_gnt = 1'b1; #1;
    check("t3_gnt_ch2", 64'(ch_gnt), 64'b100);
    check("t3_addr_c3", 64'(mem_addr), 64'h300);
    exp_q.push_back(2);
    @(negedge clk); set_ch(2, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    check("t3_gnt_ch0", 64'(ch_gnt), 64'b001);
    check("t3_addr_ch0", 64'(mem_addr), 64'h104);
    exp_q.push_back(0);
    idle(); #1;
    rsp(32'h33333333);
    rsp(32'h44444444);

    // 4: fill the tracker, stall, one response frees space
    @(negedge clk);
    mem_rvalid = 1'b0;
    set_ch(1, 1'b1, 1'b0, 32'h400, 32'h0);
    mem_gnt = 1'b1;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("t4_fill_gnt", 64'(ch_gnt), 64'b010);
      exp_q.push_back(1);
    end
    @(negedge clk); #1;
    check("t4_stall_req", 64'(mem_req), 0);
    check("t4_stall_cnt", 64'(outstanding), 4);
    check("t4_stall_gnt", 64'(ch_gnt), 0);
    rsp(32'h55555555);
    check("t4_stall_on_pop", 64'(mem_req), 0);
    @(negedge clk); mem_rvalid = 1'b0; #1;
    check("t4_resume_req", 64'(mem_req), 1);
    check("t4_resume_gnt", 64'(ch_gnt), 64'b010);
    check("t4_resume_cnt", 64'(outstanding), 3);
    exp_q.push_back(1);
    idle();
    for (int i = 0; i < MAX_OUT; i++) rsp(32'h60000000 + i);

    // 5: ch1 and ch2 contend after a fresh reset
    idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    set_ch(1, 1'b1, 1'b0, 32'h510, 32'h0);
    set_ch(2, 1'b1, 1'b0, 32'h520, 32'h0);
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int w;
`ifdef CTX_ARB_RR_EN
      w = (i % 2 == 0) ? 1 : 2;
`else
      w = 1;
`endif
      if (i > 0) @(negedge clk);
      #1;
      check("t5_gnt", 64'(ch_gnt), 64'd1 << w);
      exp_q.push_back(w);
    end
    idle(); #1;
    check("t5_outstanding", 64'(outstanding), 4);
    for (int i = 0; i < 4; i++) rsp(32'h70000000 + i);

    // 6: stray response sets a sticky error; reset clears it
    idle(); #1;
    check("t6_empty", 64'(outstanding), 0);
    @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h12345678; #1;
    check("t6_no_rvalid", 64'(ch_rvalid), 0);
    @(negedge clk); mem_rvalid = 1'b0; #1;
    check("t6_err_set", 64'(err), 1);
    check("t6_no_underflow", 64'(outstanding), 0);
    @(negedge clk); #1;
    check("t6_err_sticky", 64'(err), 1);
    rst = 1'b1; #1;
    check("t6_err_cleared", 64'(err), 0);
    @(negedge clk); rst = 1'b0;

    // Reset with a transaction in flight discards its tracking
    @(negedge clk);
    set_ch(0, 1'b1, 1'b0, 32'h200, 32'h0);
    mem_gnt = 1'b1; #1;
    check("t6_inflight_gnt", 64'(ch_gnt), 64'b001);
    idle(); #1;
    check("t6_inflight_cnt", 64'(outstanding), 1);
    rst = 1'b1; #1;
    check("t6_rst_cnt", 64'(outstanding), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    check("t6_stray_no_rvalid", 64'(ch_rvalid), 0);
    @(negedge clk); mem_rvalid = 1'b0; #1;
    check("t6_stray_err", 64'(err), 1);
    check("sb_leftover", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
